// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// Clock and reset stay outside as plain ports of the slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: MEM_DEPTH 32-bit words, byte/halfword/word access, two-cycle
// ERROR response for out-of-range, oversized or misaligned transfers.
// Optional macro AHB_SRAM_WAIT_EN: builds a wait counter and WAIT state so that every
// OKAY transfer is stretched by WAIT_STATES cycles; without it OKAY transfers complete
// in their first data-phase cycle.
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_sram_slave_if.slave bus
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef AHB_SRAM_WAIT_EN
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StErr1 = 2'd2,
        StErr2 = 2'd3
    } state_e;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_d;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StErr1 = 2'd2,
        StErr2 = 2'd3
    } state_e;
`endif

    logic [31:0]   r_mem [MEM_DEPTH];

    state_e        r_state;
    state_e        w_state_d;
    logic          r_dp_valid;   // an OKAY data phase is pending
    logic          w_dp_valid_d;
    logic          r_write;
    logic          w_write_d;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_d;
    logic [1:0]    r_lane;
    logic [1:0]    w_lane_d;
    logic [1:0]    r_size;
    logic [1:0]    w_size_d;

    logic          w_accept;
    logic          w_err;
    logic          w_complete;
    logic [3:0]    w_be;
    logic          w_unused;

`ifdef AHB_SRAM_WAIT_EN
    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};
`else
    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, (WAIT_STATES != 0)};
`endif

    // Address-phase decode: acceptance and error classification of the incoming transfer.
    always_comb begin
        w_accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                   ((r_state == StIdle) || (r_state == StErr2));
        w_err    = ({2'b00, bus.HADDR[31:2]} >= MEM_DEPTH) ||
                   (bus.HSIZE > 3'd2) ||
                   ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                   ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
        // The completing cycle of an OKAY transfer is the IDLE cycle holding a pending phase.
        w_complete = (r_state == StIdle) && r_dp_valid;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Next-state logic for the response FSM and the registered address phase.
    always_comb begin
        w_state_d    = r_state;
        w_dp_valid_d = r_dp_valid;
        w_write_d    = r_write;
        w_idx_d      = r_idx;
        w_lane_d     = r_lane;
        w_size_d     = r_size;
`ifdef AHB_SRAM_WAIT_EN
        w_wait_cnt_d = r_wait_cnt;
`endif
        case (r_state)
            StIdle: w_dp_valid_d = 1'b0;
`ifdef AHB_SRAM_WAIT_EN
            StWait: begin
                if (r_wait_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_wait_cnt_d = r_wait_cnt - CW'(1);
                end
            end
`endif
            StErr1:  w_state_d = StErr2;
            StErr2:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        if (w_accept) begin
            if (w_err) begin
                w_state_d    = StErr1;
                w_dp_valid_d = 1'b0;
            end else begin
                w_dp_valid_d = 1'b1;
                w_write_d    = bus.HWRITE;
                w_idx_d      = bus.HADDR[AW+1:2];
                w_lane_d     = bus.HADDR[1:0];
                w_size_d     = bus.HSIZE[1:0];
`ifdef AHB_SRAM_WAIT_EN
                if (WAIT_STATES != 0) begin
                    w_state_d    = StWait;
                    w_wait_cnt_d = CW'(WAIT_STATES - 1);
                end else begin
                    w_state_d = StIdle;
                end
`else
                w_state_d = StIdle;
`endif
            end
        end
    end

    // State and address-phase registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= StIdle;
            r_dp_valid <= 1'b0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
`ifdef AHB_SRAM_WAIT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_dp_valid <= w_dp_valid_d;
            r_write    <= w_write_d;
            r_idx      <= w_idx_d;
            r_lane     <= w_lane_d;
            r_size     <= w_size_d;
`ifdef AHB_SRAM_WAIT_EN
            r_wait_cnt <= w_wait_cnt_d;
`endif
        end
    end

    // Byte-lane write at the end of the completing cycle; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_complete && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Response outputs decoded from the FSM state; read data only in the completing cycle.
    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        case (r_state)
`ifdef AHB_SRAM_WAIT_EN
            StWait: bus.HREADYOUT = 1'b0;
`endif
            StErr1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            StErr2:  bus.HRESP = 1'b1;
            default: ;
        endcase
        bus.HRDATA = (w_complete && !r_write) ? r_mem[r_idx] : 32'h0;
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed vector table, hand-written pipelined
// and reset sequences, then randomized transfers against a word-array reference model.
module tb_ahb_sram_slave;
    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned WAIT_STATES = 2;
`ifdef AHB_SRAM_WAIT_EN
    localparam int EXP_WAITS = WAIT_STATES;
`else
    localparam int EXP_WAITS = 0;
`endif
    localparam int MAX_CYC = 16;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    logic r_block = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] model_mem [MEM_DEPTH];
    vec_t vecs [16];

    ahb_sram_slave_if bus ();
    assign bus.HREADY = r_block ? 1'b0 : bus.HREADYOUT;

    ahb_sram_slave #(
        .MEM_DEPTH  (MEM_DEPTH),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = 32'h0; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'd0; bus.HMASTLOCK = 1'b0;
        bus.HWDATA = 32'h0;
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
        return ((a >> 2) >= MEM_DEPTH) || (s > 3'd2) || ((s == 3'd1) && a[0]) ||
               ((s == 3'd2) && (a[1:0] != 2'd0));
    endfunction

    // Touched bytes are [addr%4, addr%4 + 2**size); data comes from the matching lanes.
    task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int off = int'(a % 4);
        int idx = int'(a / 4);
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + (1 << s)) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // One non-pipelined transfer; bus noise during the data phase, HWDATA valid only
    // once the completing cycle is seen.
    task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata, input bit exp_err,
                        input logic [31:0] exp_rdata);
        int stalls = 0;
        bit done = 1'b0;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr;
        bus.HSIZE = size; bus.HBURST = 3'($urandom); bus.HPROT = 4'($urandom);
        bus.HMASTLOCK = 1'($urandom); bus.HWDATA = $urandom;
        for (int c = 0; c < MAX_CYC && !done; c++) begin
            @(posedge HCLK); #1;
            bus.HSEL = 1'($urandom); bus.HTRANS = 2'($urandom); bus.HADDR = $urandom;
            bus.HWRITE = 1'($urandom); bus.HSIZE = 3'($urandom); bus.HWDATA = $urandom;
            @(negedge HCLK);
            if (bus.HREADYOUT) begin
                done = 1'b1;
                bus.HTRANS = 2'b00;
                bus.HWDATA = wdata;
                check({name, " resp"}, 32'(bus.HRESP), 32'(exp_err));
                check({name, " rdata"}, bus.HRDATA, (wr || exp_err) ? 32'h0 : exp_rdata);
            end else begin
                stalls++;
                check({name, " stall resp"}, 32'(bus.HRESP), 32'(exp_err));
                check({name, " stall rdata"}, bus.HRDATA, 32'h0);
            end
        end
        check({name, " stalls"}, stalls, exp_err ? 1 : EXP_WAITS);
    endtask

    initial begin
        int stalls;
        bit done;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [2:0] size;
        bit wr;
        bit err;
        int pick;

        bus_idle();

        // Reset state
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("reset hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("reset hresp", 32'(bus.HRESP), 32'd0);
        check("reset hrdata", bus.HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // No acceptance: HSEL=0, IDLE, BUSY, HREADY low (erroring address would show up)
        for (int k = 0; k < 4; k++) begin
            @(posedge HCLK); #1;
            bus.HSEL   = (k != 0);
            bus.HTRANS = (k == 1) ? 2'b00 : (k == 2) ? 2'b01 : 2'b10;
            bus.HADDR  = 32'h800; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
            r_block    = (k == 3);
            @(posedge HCLK); #1;
            bus_idle();
            r_block = 1'b0;
            @(negedge HCLK);
            check($sformatf("noaccept%0d", k), {30'h0, bus.HREADYOUT, bus.HRESP}, 32'd2);
        end

        // Directed vector table
        vecs[0]  = '{1, 32'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0};
        vecs[1]  = '{0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'h020, 3'd2, 32'h00000000, 0, 32'h0};
        vecs[3]  = '{1, 32'h021, 3'd0, 32'h0000AA00, 0, 32'h0};
        vecs[4]  = '{1, 32'h022, 3'd1, 32'h55660000, 0, 32'h0};
        vecs[5]  = '{0, 32'h020, 3'd2, 32'h0,        0, 32'h5566AA00};
        vecs[6]  = '{1, 32'h000, 3'd2, 32'h11223344, 0, 32'h0};
        vecs[7]  = '{0, 32'h400, 3'd2, 32'h0,        1, 32'h0};
        vecs[8]  = '{1, 32'h003, 3'd1, 32'hFFFFFFFF, 1, 32'h0};
        vecs[9]  = '{1, 32'h002, 3'd2, 32'hAAAAAAAA, 1, 32'h0};
        vecs[10] = '{1, 32'h000, 3'd3, 32'hBBBBBBBB, 1, 32'h0};
        vecs[11] = '{0, 32'h000, 3'd2, 32'h0,        0, 32'h11223344};
        vecs[12] = '{1, 32'h3FC, 3'd2, 32'h00000000, 0, 32'h0};
        vecs[13] = '{1, 32'h3FF, 3'd0, 32'h5A000000, 0, 32'h0};
        vecs[14] = '{0, 32'h3FC, 3'd2, 32'h0,        0, 32'h5A000000};
        vecs[15] = '{0, 32'h1000, 3'd0, 32'h0,       1, 32'h0};
        for (int i = 0; i < 16; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
                 vecs[i].wdata, vecs[i].err, vecs[i].rdata);
        end

        // Pipelined write 0x30 then read 0x30 issued in the write's completing cycle
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h30; bus.HWRITE = 1'b1;
        bus.HSIZE = 3'd2;
        stalls = 0; done = 1'b0;
        for (int c = 0; c < MAX_CYC && !done; c++) begin
            @(posedge HCLK); #1;
            bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h30; bus.HWRITE = 1'b0;
            bus.HSIZE = 3'd2; bus.HWDATA = $urandom;
            @(negedge HCLK);
            if (bus.HREADYOUT) begin
                done = 1'b1;
                bus.HWDATA = 32'hCAFEF00D;
                check("pipe wr resp", 32'(bus.HRESP), 32'd0);
            end else begin
                stalls++;
            end
        end
        check("pipe wr stalls", stalls, EXP_WAITS);
        stalls = 0; done = 1'b0;
        for (int c = 0; c < MAX_CYC && !done; c++) begin
            @(posedge HCLK); #1;
            bus_idle();
            @(negedge HCLK);
            if (bus.HREADYOUT) begin
                done = 1'b1;
                check("pipe rd data", bus.HRDATA, 32'hCAFEF00D);
                check("pipe rd resp", 32'(bus.HRESP), 32'd0);
            end else begin
                stalls++;
            end
        end
        check("pipe rd stalls", stalls, EXP_WAITS);

        // Reset during the first data-phase cycle of a write: nothing committed
        xfer("r40 init", 1'b1, 32'h40, 3'd2, 32'h0, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h40; bus.HWRITE = 1'b1;
        bus.HSIZE = 3'd2;
        @(posedge HCLK); #1;
        bus_idle();
        bus.HWDATA = 32'h12345678;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        bus.HWDATA = 32'h0;
        @(negedge HCLK);
        check("midrst hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("midrst hresp", 32'(bus.HRESP), 32'd0);
        check("midrst hrdata", bus.HRDATA, 32'h0);
        xfer("midrst read", 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'h0);

        // Randomized transfers against the reference model over a 16-word window
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            xfer($sformatf("init%0d", i), 1'b1, 32'(i * 4), 3'd2, wd, 1'b0, 32'h0);
            model_mem[i] = wd;
        end
        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom);
            pick = $urandom_range(0, 9);
            size = (pick == 9) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = (pick == 8) ? 32'(MEM_DEPTH * 4 + $urandom_range(0, 4095))
                               : 32'($urandom_range(0, 63));
            wd   = $urandom;
            err  = model_err(addr, size);
            exp_rd = err ? 32'h0 : model_mem[addr / 4];
            xfer($sformatf("rnd%0d", n), wr, addr, size, wd, err, exp_rd);
            if (wr && !err) model_write(addr, size, wd);
        end
        for (int i = 0; i < 16; i++) begin
            xfer($sformatf("final%0d", i), 1'b0, 32'(i * 4), 3'd2, 32'h0, 1'b0, model_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
